// File: rtl/onehot_alu_pipe.sv
// Two-stage ALU on one-hot operands with a valid/ready handshake and a stall-aware pipeline.
// Optional latched error flag: define ONEHOT_ALU_STICKY_ERR_EN to enable err_sticky.
module onehot_alu_pipe #(
   parameter int W   = 4,
   parameter int OPW = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [(1<<W)-1:0]   inp1,
   input  logic [(1<<W)-1:0]   inp2,
   input  logic [OPW-1:0]      opc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [(1<<W)-1:0]   out,
   output logic                overflow,
   output logic                err,
   output logic                err_sticky,
   input  logic                err_clr
);

   localparam int N  = 1 << W;
   localparam int CW = W + 1;

   if (OPW != 3) begin : gBadOpw
      $error("onehot_alu_pipe: OPW must be 3");
   end

   // Index of the highest set bit; an all-zero vector maps to 0.
   function automatic logic [W-1:0] encodeHigh(input logic [N-1:0] v);
      logic [W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) idx = W'(i);
      end
      return idx;
   endfunction

   function automatic logic notOneHot(input logic [N-1:0] v);
      logic [CW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + CW'(v[i]);
      end
      return cnt != CW'(1);
   endfunction

   logic           en;
   logic           inErr;

   logic           s1Valid_q, s1Valid_d;
   logic [W-1:0]   s1A_q, s1A_d;
   logic [W-1:0]   s1B_q, s1B_d;
   logic [OPW-1:0] s1Op_q, s1Op_d;
   logic           s1Err_q, s1Err_d;

   logic           outValid_q, outValid_d;
   logic [N-1:0]   out_q, out_d;
   logic           overflow_q, overflow_d;
   logic           err_q, err_d;

   logic [W-1:0]   res;
   logic           resOvf;
   logic [W:0]     sum;

   assign en       = !outValid_q || out_ready;
   assign in_ready = en;
   assign inErr    = notOneHot(inp1) || notOneHot(inp2);

   always_comb begin
      s1Valid_d = in_valid;
      s1A_d     = encodeHigh(inp1);
      s1B_d     = encodeHigh(inp2);
      s1Op_d    = opc;
      s1Err_d   = inErr;
   end

   // Stage 2 arithmetic; add/sub wrap mod 2**W with carry/borrow reported separately.
   always_comb begin
      res    = '0;
      resOvf = 1'b0;
      sum    = {1'b0, s1A_q} + {1'b0, s1B_q};
      case (s1Op_q)
         3'b000: res = s1A_q;
         3'b001: begin
            res    = sum[W-1:0];
            resOvf = sum[W];
         end
         3'b010: begin
            res    = s1A_q - s1B_q;
            resOvf = s1A_q < s1B_q;
         end
         3'b011: res = (s1A_q > s1B_q) ? s1A_q : s1B_q;
         3'b100: res = (s1A_q < s1B_q) ? s1A_q : s1B_q;
         3'b101: res = (s1A_q == s1B_q) ? s1A_q : '0;
         3'b110: res = s1A_q ^ s1B_q;
         default: res = s1B_q;
      endcase
   end

   // Bubbles clear the result registers so out is only non-zero alongside out_valid.
   always_comb begin
      outValid_d = s1Valid_q;
      out_d      = '0;
      overflow_d = 1'b0;
      err_d      = 1'b0;
      if (s1Valid_q) begin
         out_d      = N'(1) << res;
         overflow_d = resOvf;
         err_d      = s1Err_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q  <= 1'b0;
         s1A_q      <= '0;
         s1B_q      <= '0;
         s1Op_q     <= '0;
         s1Err_q    <= 1'b0;
         outValid_q <= 1'b0;
         out_q      <= '0;
         overflow_q <= 1'b0;
         err_q      <= 1'b0;
      end else if (en) begin
         s1Valid_q  <= s1Valid_d;
         s1A_q      <= s1A_d;
         s1B_q      <= s1B_d;
         s1Op_q     <= s1Op_d;
         s1Err_q    <= s1Err_d;
         outValid_q <= outValid_d;
         out_q      <= out_d;
         overflow_q <= overflow_d;
         err_q      <= err_d;
      end
   end

   assign out_valid = outValid_q;
   assign out       = out_q;
   assign overflow  = overflow_q;
   assign err       = err_q;

`ifdef ONEHOT_ALU_STICKY_ERR_EN
   logic errSticky_q, errSticky_d;

   // Set on an accepted erroneous beat takes priority over a same-cycle clear.
   always_comb begin
      errSticky_d = errSticky_q;
      if (err_clr) errSticky_d = 1'b0;
      if (in_valid && en && inErr) errSticky_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) errSticky_q <= 1'b0;
      else        errSticky_q <= errSticky_d;
   end

   assign err_sticky = errSticky_q;
`else
   logic unusedErrClr;
   assign unusedErrClr = err_clr;
   assign err_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_alu_pipe.sv
// Directed bench for onehot_alu_pipe (W=4): arithmetic, compare ops, errors, stalls and reset.
module tb_onehot_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] inp1;
   logic [15:0] inp2;
   logic [2:0]  opc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out;
   logic        overflow;
   logic        err;
   logic        err_sticky;
   logic        err_clr;

   int checks   = 0;
   int failures = 0;

   onehot_alu_pipe #(.W(4), .OPW(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .inp1       (inp1),
      .inp2       (inp2),
      .opc        (opc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out),
      .overflow   (overflow),
      .err        (err),
      .err_sticky (err_sticky),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   // Single beat: accepted on the first edge, result visible after the second edge.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] op, output logic earlyValid);
      @(negedge clk);
      inp1 = a; inp2 = b; opc = op; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1 earlyValid = out_valid;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; inp1 = '0; inp2 = '0; opc = '0;
      out_ready = 1'b1; err_clr = 1'b0;
      #12;
      checks++; if (out_valid !== 1'b0) begin $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); failures++; end
      checks++; if (out !== 16'h0000) begin $display("[TB] FAIL reset_out got=%h want=0000", out); failures++; end
      checks++; if (overflow !== 1'b0 || err !== 1'b0) begin $display("[TB] FAIL reset_flags got ovf=%b err=%b want 0/0", overflow, err); failures++; end
      checks++; if (err_sticky !== 1'b0) begin $display("[TB] FAIL reset_sticky got=%b want=0", err_sticky); failures++; end
      checks++; if (in_ready !== 1'b1) begin $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); failures++; end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin $display("[TB] FAIL post_reset_in_ready got=%b want=1", in_ready); failures++; end
   endtask

   task automatic test_add_sub();
      logic early;
      applyStimulus(16'h0008, 16'h0010, 3'b001, early);
      checks++; if (early !== 1'b0) begin $display("[TB] FAIL latency_early got=%b want=0", early); failures++; end
      checks++; if (out_valid !== 1'b1 || out !== 16'h0080 || overflow !== 1'b0 || err !== 1'b0)
         begin $display("[TB] FAIL add_3_4 got v=%b out=%h ovf=%b err=%b want 1/0080/0/0", out_valid, out, overflow, err); failures++; end
      applyStimulus(16'h8000, 16'h0004, 3'b001, early);
      checks++; if (out !== 16'h0002 || overflow !== 1'b1)
         begin $display("[TB] FAIL add_wrap got out=%h ovf=%b want 0002/1", out, overflow); failures++; end
      applyStimulus(16'h0004, 16'h0020, 3'b010, early);
      checks++; if (out !== 16'h2000 || overflow !== 1'b1)
         begin $display("[TB] FAIL sub_borrow got out=%h ovf=%b want 2000/1", out, overflow); failures++; end
      applyStimulus(16'h8000, 16'h0001, 3'b001, early);
      checks++; if (out !== 16'h8000 || overflow !== 1'b0)
         begin $display("[TB] FAIL add_max_no_carry got out=%h ovf=%b want 8000/0", out, overflow); failures++; end
      applyStimulus(16'h0080, 16'h0080, 3'b010, early);
      checks++; if (out !== 16'h0001 || overflow !== 1'b0)
         begin $display("[TB] FAIL sub_equal got out=%h ovf=%b want 0001/0", out, overflow); failures++; end
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin $display("[TB] FAIL bubble_valid got=%b want=0", out_valid); failures++; end
   endtask

   task automatic test_compare_ops();
      logic early;
      applyStimulus(16'h0200, 16'h0008, 3'b011, early);
      checks++; if (out !== 16'h0200 || overflow !== 1'b0) begin $display("[TB] FAIL max got out=%h ovf=%b want 0200/0", out, overflow); failures++; end
      applyStimulus(16'h0200, 16'h0008, 3'b100, early);
      checks++; if (out !== 16'h0008) begin $display("[TB] FAIL min got=%h want=0008", out); failures++; end
      applyStimulus(16'h0200, 16'h0008, 3'b101, early);
      checks++; if (out !== 16'h0001) begin $display("[TB] FAIL eq_diff got=%h want=0001", out); failures++; end
      applyStimulus(16'h0040, 16'h0040, 3'b101, early);
      checks++; if (out !== 16'h0040) begin $display("[TB] FAIL eq_same got=%h want=0040", out); failures++; end
      applyStimulus(16'h0020, 16'h0008, 3'b110, early);
      checks++; if (out !== 16'h0040) begin $display("[TB] FAIL xor got=%h want=0040", out); failures++; end
      applyStimulus(16'h0020, 16'h0008, 3'b111, early);
      checks++; if (out !== 16'h0008) begin $display("[TB] FAIL pass_b got=%h want=0008", out); failures++; end
      applyStimulus(16'h0020, 16'h0008, 3'b000, early);
      checks++; if (out !== 16'h0020) begin $display("[TB] FAIL pass_a got=%h want=0020", out); failures++; end
   endtask

   task automatic test_error();
      logic early;
      applyStimulus(16'h0003, 16'h0000, 3'b000, early);
      checks++; if (out !== 16'h0002 || err !== 1'b1)
         begin $display("[TB] FAIL err_beat got out=%h err=%b want 0002/1", out, err); failures++; end
`ifdef ONEHOT_ALU_STICKY_ERR_EN
      checks++; if (err_sticky !== 1'b1) begin $display("[TB] FAIL sticky_set got=%b want=1", err_sticky); failures++; end
      applyStimulus(16'h0001, 16'h0001, 3'b000, early);
      checks++; if (err !== 1'b0 || err_sticky !== 1'b1)
         begin $display("[TB] FAIL sticky_hold got err=%b sticky=%b want 0/1", err, err_sticky); failures++; end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0; #1;
      checks++; if (err_sticky !== 1'b0) begin $display("[TB] FAIL sticky_clear got=%b want=0", err_sticky); failures++; end
      @(negedge clk);
      inp1 = 16'h0000; inp2 = 16'h0001; opc = 3'b000; in_valid = 1'b1; err_clr = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; err_clr = 1'b0; #1;
      checks++; if (err_sticky !== 1'b1) begin $display("[TB] FAIL sticky_set_wins got=%b want=1", err_sticky); failures++; end
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
`else
      checks++; if (err_sticky !== 1'b0) begin $display("[TB] FAIL sticky_tied got=%b want=0", err_sticky); failures++; end
`endif
      applyStimulus(16'h0100, 16'h0002, 3'b001, early);
      checks++; if (out !== 16'h0200 || err !== 1'b0)
         begin $display("[TB] FAIL err_cleared_beat got out=%h err=%b want 0200/0", out, err); failures++; end
   endtask

   task automatic test_back_to_back();
      logic [15:0] aTab [8];
      logic [15:0] expTab [8];
      int          sent = 0;
      int          recv = 0;
      logic        stalledPrev = 1'b0;
      logic [15:0] heldOut = '0;
      logic        heldOvf = 1'b0;
      aTab   = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080};
      expTab = '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0100};
      for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 3 && cyc <= 6);
         if (sent < 8) begin
            in_valid = 1'b1; inp1 = aTab[sent]; inp2 = 16'h0002; opc = 3'b001;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (stalledPrev) begin
            checks++;
            if (out_valid !== 1'b1 || out !== heldOut || overflow !== heldOvf)
               begin $display("[TB] FAIL stall_hold cyc=%0d got v=%b out=%h want 1/%h", cyc, out_valid, out, heldOut); failures++; end
         end
         if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin $display("[TB] FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready); failures++; end
            stalledPrev = 1'b1; heldOut = out; heldOvf = overflow;
         end else begin
            stalledPrev = 1'b0;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (out !== expTab[recv]) begin $display("[TB] FAIL b2b_beat%0d got=%h want=%h", recv, out, expTab[recv]); failures++; end
            recv++;
         end
         if (in_valid && in_ready) sent++;
      end
      checks++; if (recv != 8) begin $display("[TB] FAIL b2b_count got=%0d want=8", recv); failures++; end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checks++; if (out_valid !== 1'b0) begin $display("[TB] FAIL b2b_extra cyc=%0d got=%b want=0", i, out_valid); failures++; end
      end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; inp1 = 16'h0002; inp2 = 16'h0002; opc = 3'b001;
      @(negedge clk);
      inp1 = 16'h0004; inp2 = 16'h0002; opc = 3'b001;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out !== 16'h0004)
         begin $display("[TB] FAIL inflight_before got v=%b out=%h want 1/0004", out_valid, out); failures++; end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out !== 16'h0000)
         begin $display("[TB] FAIL reset_async got v=%b out=%h want 0/0000", out_valid, out); failures++; end
      checks++; if (in_ready !== 1'b1) begin $display("[TB] FAIL reset_mid_in_ready got=%b want=1", in_ready); failures++; end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checks++; if (out_valid !== 1'b0) begin $display("[TB] FAIL stale_beat cyc=%0d got=%b want=0", i, out_valid); failures++; end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_compare_ops();
      test_error();
      test_back_to_back();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
